// File: rtl/y_serializer_pkg.sv
// Shared constants and state encoding for the Y result serializer.
package y_serializer_pkg;

    localparam int DATA_W  = 20;
    localparam int N_WORDS = 9;
    localparam int IDX_W   = 4;
    localparam int SUM_W   = DATA_W + 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/y_serializer_sum9.sv
// Combinational nine-input adder; every word is sign-extended to the sum
// width first, so nine full-scale words can never overflow.
module ser_sum9 #(
    parameter int DATA_W = y_serializer_pkg::DATA_W,
    parameter int SUM_W  = y_serializer_pkg::SUM_W
) (
    input  logic signed [DATA_W-1:0] words [9],
    output logic signed [SUM_W-1:0]  sum
);

    logic signed [SUM_W-1:0] acc;

    // Accumulate the sign-extended words.
    always_comb begin
        acc = '0;
        for (int k = 0; k < 9; k++) begin
            acc = acc + {{(SUM_W - DATA_W){words[k][DATA_W-1]}}, words[k]};
        end
    end

    assign sum = acc;

endmodule

// File: rtl/y_serializer.sv
// Captures the nine parallel Y results on load and streams them out one word
// per transfer, index 0 first, with the frame sum available alongside.
//
// Handshake: a word moves downstream on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data/out_idx/out_last stay unchanged. out_valid never depends on
// out_ready.
module y_serializer #(
    parameter int DATA_W  = y_serializer_pkg::DATA_W,
    parameter int N_WORDS = y_serializer_pkg::N_WORDS
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   load,
    input  logic signed [DATA_W-1:0]               Y_0,
    input  logic signed [DATA_W-1:0]               Y_1,
    input  logic signed [DATA_W-1:0]               Y_2,
    input  logic signed [DATA_W-1:0]               Y_3,
    input  logic signed [DATA_W-1:0]               Y_4,
    input  logic signed [DATA_W-1:0]               Y_5,
    input  logic signed [DATA_W-1:0]               Y_6,
    input  logic signed [DATA_W-1:0]               Y_7,
    input  logic signed [DATA_W-1:0]               Y_8,
    output logic signed [DATA_W-1:0]               out_data,
    output logic [y_serializer_pkg::IDX_W-1:0]     out_idx,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic signed [DATA_W+3:0]               frame_sum,
    output logic                                   busy,
    output logic                                   overrun,
    output logic                                   fsm_state
);

    import y_serializer_pkg::*;

    localparam int SUM_WIDTH = DATA_W + 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         next_idx;
    logic signed [DATA_W-1:0] bank  [N_WORDS];
    logic signed [DATA_W-1:0] y_vec [N_WORDS];
    logic signed [SUM_WIDTH-1:0] sum_now;

    assign y_vec[0] = Y_0;
    assign y_vec[1] = Y_1;
    assign y_vec[2] = Y_2;
    assign y_vec[3] = Y_3;
    assign y_vec[4] = Y_4;
    assign y_vec[5] = Y_5;
    assign y_vec[6] = Y_6;
    assign y_vec[7] = Y_7;
    assign y_vec[8] = Y_8;

    assign next_idx  = idx + 1'b1;
    assign out_idx   = idx;
    assign busy      = (state == SEND);
    assign fsm_state = state;

    ser_sum9 #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_WIDTH)
    ) u_sum (
        .words (y_vec),
        .sum   (sum_now)
    );

    // Frame FSM: capture in IDLE, one word per transfer in SEND; a load seen
    // in SEND (including the final transfer cycle) is dropped and flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_sum <= '0;
            overrun   <= 1'b0;
            for (int k = 0; k < N_WORDS; k++) begin
                bank[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        for (int k = 0; k < N_WORDS; k++) begin
                            bank[k] <= y_vec[k];
                        end
                        idx       <= '0;
                        out_data  <= y_vec[0];
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        frame_sum <= sum_now;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (load) begin
                        overrun <= 1'b1;
                    end
                    if (idx > LAST_IDX) begin
                        // Illegal index: abandon the frame.
                        state     <= IDLE;
                        idx       <= '0;
                        out_data  <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (out_valid && out_ready) begin
                        if (idx == LAST_IDX) begin
                            state     <= IDLE;
                            idx       <= '0;
                            out_data  <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            idx      <= next_idx;
                            out_data <= bank[next_idx];
                            out_last <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y_serializer.sv
// Self-checking bench for y_serializer: table of frames driven through a
// scoreboard, plus hand-written reset and mid-frame reset sequences.
module tb_y_serializer;

    logic               clk;
    logic               reset;
    logic               load;
    logic signed [19:0] y_arr [9];
    logic signed [19:0] out_data;
    logic [3:0]         out_idx;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic signed [23:0] frame_sum;
    logic               busy;
    logic               overrun;
    logic               fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    // {last, idx, data}
    logic [24:0]        exp_q[$];
    logic signed [23:0] exp_sum;

    typedef struct {
        logic signed [19:0] base;
        int                 step;
        int                 stall_at;
        int                 stall_len;
        int                 pulse_at;
        bit                 pulse_last;
        logic signed [23:0] exp_sum;
        bit                 exp_overrun;
    } vec_t;

    vec_t vecs [7];

    y_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .Y_0       (y_arr[0]),
        .Y_1       (y_arr[1]),
        .Y_2       (y_arr[2]),
        .Y_3       (y_arr[3]),
        .Y_4       (y_arr[4]),
        .Y_5       (y_arr[5]),
        .Y_6       (y_arr[6]),
        .Y_7       (y_arr[7]),
        .Y_8       (y_arr[8]),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_sum (frame_sum),
        .busy      (busy),
        .overrun   (overrun),
        .fsm_state (fsm_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: pop one expected beat per accepted transfer.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", longint'(out_idx), -1);
            end else begin
                logic [24:0] e;
                e = exp_q.pop_front();
                check("beat_data", longint'(out_data), longint'($signed(e[19:0])));
                check("beat_idx", longint'(out_idx), longint'(e[23:20]));
                check("beat_last", longint'(out_last), longint'(e[24]));
                if (e[24]) begin
                    check("frame_sum", longint'(frame_sum), longint'(exp_sum));
                end
            end
        end
    end

    // Drive one table frame: load, run with optional stall/load pulses, check.
    task automatic run_frame(input int f);
        vec_t               v;
        logic signed [19:0] w [9];
        int                 cycles;
        int                 stalled;
        bit                 pulsed;
        v = vecs[f];
        @(posedge clk); #1;
        for (int k = 0; k < 9; k++) begin
            w[k]     = v.base + 20'(v.step * k);
            y_arr[k] = w[k];
            exp_q.push_back({(k == 8), 4'(k), w[k]});
        end
        exp_sum   = v.exp_sum;
        load      = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check("first_valid", longint'(out_valid), 1);
        check("busy_in_frame", longint'(busy), 1);
        check("fsm_state_send", longint'(fsm_state), 1);
        cycles  = 0;
        stalled = 0;
        pulsed  = 1'b0;
        while (out_valid && cycles < 60) begin
            out_ready = 1'b1;
            load      = 1'b0;
            if (int'(out_idx) == v.stall_at && stalled < v.stall_len) begin
                out_ready = 1'b0;
                stalled++;
                check("hold_data", longint'(out_data), longint'(w[v.stall_at]));
                check("hold_idx", longint'(out_idx), longint'(v.stall_at));
            end
            if ((int'(out_idx) == v.pulse_at && !pulsed) || (v.pulse_last && out_idx == 4'd8)) begin
                load = 1'b1;
                if (int'(out_idx) == v.pulse_at) pulsed = 1'b1;
                for (int k = 0; k < 9; k++) y_arr[k] = 20'sd77777;
            end
            cycles++;
            @(posedge clk); #1;
        end
        load      = 1'b0;
        out_ready = 1'b1;
        check("frame_cycles", longint'(cycles), longint'(9 + v.stall_len));
        check("idle_after", longint'(out_valid), 0);
        check("busy_after", longint'(busy), 0);
        check("sum_held", longint'(frame_sum), longint'(v.exp_sum));
        check("overrun", longint'(overrun), longint'(v.exp_overrun));
        check("q_empty", longint'(exp_q.size()), 0);
        if (v.pulse_last) begin
            @(posedge clk); #1;
            check("no_back_to_back", longint'(out_valid), 0);
        end
    endtask

    initial begin
        int cnt;
        vecs[0] = '{base: 20'sd1,     step: 1,   stall_at: -1, stall_len: 0, pulse_at: -1, pulse_last: 1'b0, exp_sum: 24'sd45,       exp_overrun: 1'b0};
        vecs[1] = '{base: 20'sd1,     step: 1,   stall_at: 4,  stall_len: 3, pulse_at: -1, pulse_last: 1'b0, exp_sum: 24'sd45,       exp_overrun: 1'b0};
        vecs[2] = '{base: 20'sh80000, step: 0,   stall_at: -1, stall_len: 0, pulse_at: -1, pulse_last: 1'b0, exp_sum: -24'sd4718592, exp_overrun: 1'b0};
        vecs[3] = '{base: 20'sh7FFFF, step: 0,   stall_at: -1, stall_len: 0, pulse_at: -1, pulse_last: 1'b0, exp_sum: 24'sd4718583,  exp_overrun: 1'b0};
        vecs[4] = '{base: -20'sd100,  step: 25,  stall_at: -1, stall_len: 0, pulse_at: -1, pulse_last: 1'b0, exp_sum: 24'sd0,        exp_overrun: 1'b0};
        vecs[5] = '{base: 20'sd1000,  step: -300, stall_at: -1, stall_len: 0, pulse_at: 3, pulse_last: 1'b1, exp_sum: -24'sd1800,    exp_overrun: 1'b1};
        vecs[6] = '{base: 20'sd7,     step: 3,   stall_at: -1, stall_len: 0, pulse_at: -1, pulse_last: 1'b0, exp_sum: 24'sd171,      exp_overrun: 1'b0};

        reset     = 1'b0;
        load      = 1'b0;
        out_ready = 1'b0;
        exp_sum   = '0;
        for (int k = 0; k < 9; k++) y_arr[k] = '0;

        // Reset held two cycles: every output at zero.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_idx", longint'(out_idx), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_last", longint'(out_last), 0);
        check("rst_frame_sum", longint'(frame_sum), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_overrun", longint'(overrun), 0);
        check("rst_fsm_state", longint'(fsm_state), 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_load", longint'(out_valid), 0);

        // Table frames 0..5 (frame 5 provokes overrun).
        for (int f = 0; f < 6; f++) begin
            run_frame(f);
        end
        repeat (3) @(posedge clk);
        #1;
        check("overrun_sticky", longint'(overrun), 1);

        // Reset in the middle of a frame at idx 5.
        for (int k = 0; k < 9; k++) begin
            y_arr[k] = 20'sd50 + 20'(k);
            exp_q.push_back({(k == 8), 4'(k), y_arr[k]});
        end
        exp_sum   = 24'sd486;
        out_ready = 1'b1;
        load      = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        cnt  = 0;
        while (out_idx != 4'd5 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("reach_idx5", longint'(out_idx), 5);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", longint'(out_valid), 0);
        check("mid_rst_idx", longint'(out_idx), 0);
        check("mid_rst_data", longint'(out_data), 0);
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_sum", longint'(frame_sum), 0);
        check("mid_rst_overrun", longint'(overrun), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", longint'(out_valid), 0);

        // Fresh frame after release starts at index 0 with new data.
        run_frame(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/y_serializer.md
Y_SERIALIZER -- requirements
Module: y_serializer

Interface
REQ-001 Parameter DATA_W, default 20, width of each signed result word.
REQ-002 Parameter N_WORDS, default 9, results per frame (fixed by the top_level result set Y_0..Y_8).
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port load, input, 1, capture strobe: Y_0..Y_8 valid this cycle.
REQ-006 Ports Y_0..Y_8, input, DATA_W each, signed parallel results from top_level.
REQ-007 Port out_data, output, DATA_W, signed current serial word.
REQ-008 Port out_idx, output, 4, index (0..8) of out_data.
REQ-009 Port out_valid, output, 1, out_data/out_idx valid.
REQ-010 Port out_ready, input, 1, downstream accepts the word when out_valid and out_ready are both high.
REQ-011 Port out_last, output, 1, high with out_valid on index 8.
REQ-012 Port frame_sum, output, DATA_W+4, signed sum of the nine captured words; valid with out_last.
REQ-013 Port busy, output, 1, high while in SEND.
REQ-014 Port overrun, output, 1, sticky: load arrived while busy.

Function
REQ-015 FSM SHALL have two states, IDLE and SEND.
REQ-016 IDLE + load=1: capture all nine words into an internal register bank, idx<=0, compute frame_sum, go to SEND on the next edge.
REQ-017 SEND: out_valid=1, out_data=bank[idx], out_idx=idx.
REQ-018 Beat transfer: out_valid & out_ready; idx increments by 1 per transfer.
REQ-019 out_ready=0 in SEND: out_data, out_idx, out_valid held stable, no advance.
REQ-020 Transfer at idx=8: go to IDLE, out_valid=0 next cycle, idx<=0.
REQ-021 Latency: load at edge N gives the first out_valid after edge N; a full frame with out_ready held high takes exactly 9 cycles.
REQ-022 Load in SEND: ignored, bank unchanged, overrun<=1; overrun clears only on reset.
REQ-023 Load in the same cycle as the idx=8 transfer: treated as in SEND, so ignored and overrun set; there is no back-to-back capture.
REQ-024 frame_sum: sign-extend each word to DATA_W+4 before summing; no saturation (9 x 2^19 fits in 24 bits).
REQ-025 frame_sum is registered at capture and held until the next capture.
REQ-026 out_last = out_valid & (idx==8).
REQ-027 idx never exceeds 8; any other value returns the FSM to IDLE.

Reset
REQ-028 reset low: state=IDLE, idx=0, bank=0, out_data=0, out_idx=0, out_valid=0, out_last=0, frame_sum=0, busy=0, overrun=0, asynchronously.
REQ-029 Reset asserted mid-frame aborts the frame; after release the block waits for a new load.

Structure
REQ-030 Shared package holds DATA_W, N_WORDS, IDX_W=4, SUM_W=DATA_W+4, and the state encoding IDLE=1'b0, SEND=1'b1.
REQ-031 One sub-module, ser_sum9: combinational sign-extending 9-input adder producing SUM_W.
REQ-032 Target size is 150-300 lines of RTL.

Verification
REQ-033 Reset/idle: hold reset low 2 cycles -> all outputs 0; release with no load -> out_valid stays 0.
REQ-034 Basic frame: Y_k=k+1, load 1 cycle, out_ready=1 -> 9 consecutive beats with out_data 1..9, out_idx 0..8, out_last only on the 9th, frame_sum=45.
REQ-035 Backpressure: same frame, out_ready=0 for 3 cycles at idx=4 -> out_data=5 held 4 cycles, then 6..9 follow, total 12 cycles.
REQ-036 Negative/extreme values: all Y_k=-524288 -> each out_data=-524288, frame_sum=-4718592; all Y_k=524287 -> frame_sum=4718583.
REQ-037 Overrun: load at idx=3, and load at the idx=8 transfer -> bank unchanged, frame stays intact, overrun=1 until reset.
REQ-038 Reset mid-frame: reset low at idx=5 -> out_valid=0 immediately; a new load after release starts at idx=0 with the new data.
